// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI controller: FSM state encoding and
// the SCLK half-period calculation.
package spi_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        HOLD
    } spi_state_t;

    localparam int BITS_PER_BYTE = 8;

    // System clocks per SCLK phase; callers must keep the result at 2 or more.
    function automatic int half_period(input int clk_frequency, input int sclk_frequency);
        return clk_frequency / (2 * sclk_frequency);
    endfunction

endpackage

// File: rtl/spi_sclk_timer.sv
// Half-period down-counter: reloads on load and reports expire once HALF
// clocks have elapsed since the last load.
module spi_sclk_timer #(
    parameter int HALF = 100
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic expire
);

    localparam int W = (HALF > 1) ? $clog2(HALF) : 1;

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= W'(HALF - 1);
        end else if (count != '0) begin
            count <= count - W'(1);
        end
    end

    assign expire = (count == '0);

endmodule

// File: rtl/spi_controller_core.sv
// Mode-0 SPI controller, MSB first, one byte per start; hold_cs keeps CS
// asserted across bytes for multi-byte transactions.
import spi_pkg::*;

module spi_controller_core #(
    parameter int CLK_FREQUENCY  = 100_000_000,
    parameter int SCLK_FREQUENCY = 500_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data_to_send,
    input  logic       hold_cs,
    input  logic       SPI_MISO,
    output logic [7:0] data_received,
    output logic       busy,
    output logic       done,
    output logic       SPI_SCLK,
    output logic       SPI_MOSI,
    output logic       SPI_CS
);

    localparam int HALF = half_period(CLK_FREQUENCY, SCLK_FREQUENCY);
    localparam logic [2:0] LAST_BIT = 3'(BITS_PER_BYTE - 1);

    spi_state_t state, next_state;

    logic       expire;
    logic       load;
    logic       accept;
    logic       rise;
    logic       fall_next;
    logic       fall_last;
    logic       release_cs;
    logic [7:0] tx_shift;
    logic [7:0] rx_shift;
    logic [2:0] bit_cnt;

    spi_sclk_timer #(
        .HALF(HALF)
    ) u_timer (
        .clk   (clk),
        .rst   (rst),
        .load  (load),
        .expire(expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // In HOLD a new start wins over releasing CS, so chained bytes never glitch CS.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: if (start) next_state = LOW;
            LOW:  if (expire) next_state = HIGH;
            HIGH: begin
                if (expire) begin
                    if (bit_cnt != LAST_BIT) begin
                        next_state = LOW;
                    end else begin
                        next_state = hold_cs ? HOLD : IDLE;
                    end
                end
            end
            HOLD: begin
                if (start) begin
                    next_state = LOW;
                end else if (!hold_cs) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        accept     = ((state == IDLE) || (state == HOLD)) && start;
        rise       = (state == LOW) && expire;
        fall_next  = (state == HIGH) && expire && (bit_cnt != LAST_BIT);
        fall_last  = (state == HIGH) && expire && (bit_cnt == LAST_BIT);
        release_cs = (state == HOLD) && !start && !hold_cs;
        load       = accept || rise || fall_next;
    end

    // All pins are registered so MOSI, SCLK and CS move on the same edge as the FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_shift      <= '0;
            rx_shift      <= '0;
            bit_cnt       <= '0;
            data_received <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            SPI_SCLK      <= 1'b0;
            SPI_CS        <= 1'b1;
        end else begin
            done <= fall_last;
            if (accept) begin
                tx_shift <= data_to_send;
                bit_cnt  <= '0;
                SPI_CS   <= 1'b0;
                busy     <= 1'b1;
            end
            if (rise) begin
                SPI_SCLK <= 1'b1;
                rx_shift <= {rx_shift[6:0], SPI_MISO};
            end
            if (fall_next) begin
                SPI_SCLK <= 1'b0;
                tx_shift <= {tx_shift[6:0], 1'b0};
                bit_cnt  <= bit_cnt + 3'd1;
            end
            if (fall_last) begin
                SPI_SCLK      <= 1'b0;
                data_received <= rx_shift;
                busy          <= 1'b0;
                if (!hold_cs) begin
                    SPI_CS <= 1'b1;
                end
            end
            if (release_cs) begin
                SPI_CS <= 1'b1;
            end
        end
    end

    assign SPI_MOSI = tx_shift[7];

endmodule

// File: tb/tb_spi_controller_core.sv
// Bench for spi_controller_core: inline mode-0 peripheral model plus a
// done-triggered scoreboard fed by the stimulus tasks.
module tb_spi_controller_core;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] data_to_send;
    logic       hold_cs;
    logic       SPI_MISO;
    logic [7:0] data_received;
    logic       busy;
    logic       done;
    logic       SPI_SCLK;
    logic       SPI_MOSI;
    logic       SPI_CS;

    typedef struct {
        logic [7:0] tx;
        logic [7:0] rx;
        int         startCycle;
        logic       csAtDone;
    } exp_t;

    exp_t       expQ[$];
    logic [7:0] capQ[$];
    exp_t       mon;
    logic [7:0] monCap;

    int   passCount  = 0;
    int   totalCount = 0;
    int   cycle      = 0;
    int   doneCount  = 0;
    int   csGlitches = 0;
    logic prevDone   = 1'b0;

    logic [7:0] sub_reply = 8'h00;
    logic [7:0] sub_shift = 8'h00;
    logic [2:0] sub_in_bits = 3'd0;
    logic [2:0] sub_out_bits = 3'd0;

    logic [7:0] txTab[10] = '{8'h00, 8'hFF, 8'h01, 8'h80, 8'h55, 8'hAA, 8'h3C, 8'hC3, 8'h7E, 8'h96};
    logic [7:0] rxTab[10] = '{8'hFF, 8'h00, 8'h80, 8'h01, 8'hAA, 8'h55, 8'hC3, 8'h3C, 8'h69, 8'h0F};

    spi_controller_core dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .data_to_send (data_to_send),
        .hold_cs      (hold_cs),
        .SPI_MISO     (SPI_MISO),
        .data_received(data_received),
        .busy         (busy),
        .done         (done),
        .SPI_SCLK     (SPI_SCLK),
        .SPI_MOSI     (SPI_MOSI),
        .SPI_CS       (SPI_CS)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cycle <= cycle + 1;

    // Peripheral: captures MOSI on SCLK rise, shifts its reply out on SCLK fall.
    assign SPI_MISO = sub_reply[3'd7 - sub_out_bits];

    always @(posedge SPI_SCLK) begin
        if (SPI_CS === 1'b0) begin
            sub_shift = {sub_shift[6:0], SPI_MOSI};
            if (sub_in_bits == 3'd7) capQ.push_back(sub_shift);
            sub_in_bits = sub_in_bits + 3'd1;
        end
    end

    always @(negedge SPI_SCLK) begin
        if (SPI_CS === 1'b0) sub_out_bits = sub_out_bits + 3'd1;
    end

    always @(posedge SPI_CS) begin
        sub_in_bits  = 3'd0;
        sub_out_bits = 3'd0;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        totalCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: actual %0h, required %0h", name, actual, expected);
        end
    endtask

    always @(negedge clk) begin
        if (prevDone) checkOutput("done_width", 32'(done), 32'd0);
        prevDone = done;
        if (busy === 1'b1 && SPI_CS !== 1'b0) csGlitches++;
        if (done === 1'b1) begin
            doneCount++;
            if (expQ.size() == 0) begin
                checkOutput("unexpected_done", 32'd1, 32'd0);
            end else begin
                mon    = expQ.pop_front();
                monCap = (capQ.size() != 0) ? capQ.pop_front() : 8'hxx;
                checkOutput("mosi_capture", 32'(monCap), 32'(mon.tx));
                checkOutput("data_received", 32'(data_received), 32'(mon.rx));
                checkOutput("done_latency", cycle - mon.startCycle, 32'd1601);
                checkOutput("cs_at_done", 32'(SPI_CS), 32'(mon.csAtDone));
            end
        end
    end

    task automatic applyStimulus(input logic [7:0] tx, input logic [7:0] rx, input logic hold);
        exp_t e;
        e.tx         = tx;
        e.rx         = rx;
        e.startCycle = cycle;
        e.csAtDone   = ~hold;
        expQ.push_back(e);
        hold_cs      = hold;
        sub_reply    = rx;
        data_to_send = tx;
        start        = 1'b1;
        @(negedge clk);
        start        = 1'b0;
        data_to_send = ~tx;
        checkOutput("cs_after_start", 32'(SPI_CS), 32'd0);
        checkOutput("busy_after_start", 32'(busy), 32'd1);
        checkOutput("mosi_first_bit", 32'(SPI_MOSI), 32'(tx[7]));
    endtask

    task automatic waitDone(input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            totalCount++;
            $display("[TB] FAIL done_timeout: no done within %0d cycles", budget);
        end
    endtask

    task automatic waitSclk(input logic level, output int t);
        int n = 0;
        while (SPI_SCLK !== level && n < 1000) begin
            @(negedge clk);
            n++;
        end
        t = cycle;
        if (SPI_SCLK !== level) begin
            totalCount++;
            $display("[TB] FAIL sclk_timeout: SCLK never reached %0b", level);
        end
    endtask

    task automatic measureSclk(input int startCycle);
        int tRise, tFall, tRise2;
        waitSclk(1'b1, tRise);
        waitSclk(1'b0, tFall);
        waitSclk(1'b1, tRise2);
        checkOutput("sclk_first_rise", tRise - startCycle, 32'd101);
        checkOutput("sclk_high_time", tFall - tRise, 32'd100);
        checkOutput("sclk_period", tRise2 - tRise, 32'd200);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not complete");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int t0;
        int doneBefore;
        rst          = 1'b1;
        start        = 1'b0;
        hold_cs      = 1'b0;
        data_to_send = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("reset_sclk", 32'(SPI_SCLK), 32'd0);
        checkOutput("reset_cs", 32'(SPI_CS), 32'd1);
        checkOutput("reset_mosi", 32'(SPI_MOSI), 32'd0);
        checkOutput("reset_busy", 32'(busy), 32'd0);
        checkOutput("reset_done", 32'(done), 32'd0);
        checkOutput("reset_data_received", 32'(data_received), 32'd0);

        $display("[TB] single byte A5 / 3C");
        applyStimulus(8'hA5, 8'h3C, 1'b0);
        waitDone(2000);

        $display("[TB] ten back-to-back bytes");
        for (int i = 0; i < 10; i++) begin
            t0 = cycle;
            applyStimulus(txTab[i], rxTab[i], 1'b0);
            if (i == 0) measureSclk(t0);
            waitDone(2000);
        end

        $display("[TB] multi-byte with hold_cs");
        applyStimulus(8'h12, 8'h55, 1'b1);
        waitDone(2000);
        repeat (5) @(negedge clk);
        checkOutput("hold_cs_low", 32'(SPI_CS), 32'd0);
        checkOutput("hold_not_busy", 32'(busy), 32'd0);
        applyStimulus(8'h34, 8'hAA, 1'b1);
        waitDone(2000);
        repeat (3) @(negedge clk);
        checkOutput("hold_cs_low_2", 32'(SPI_CS), 32'd0);
        hold_cs = 1'b0;
        @(negedge clk);
        checkOutput("release_cs_high", 32'(SPI_CS), 32'd1);

        $display("[TB] start while busy is ignored");
        applyStimulus(8'h5A, 8'hC3, 1'b0);
        repeat (850) @(negedge clk);
        data_to_send = 8'hFF;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        waitDone(2000);

        $display("[TB] start and release together in HOLD");
        @(negedge clk);
        applyStimulus(8'h81, 8'h18, 1'b1);
        waitDone(2000);
        repeat (2) @(negedge clk);
        applyStimulus(8'h7E, 8'hE7, 1'b0);
        waitDone(2000);
        checkOutput("cs_glitches", csGlitches, 32'd0);

        $display("[TB] reset mid-transfer");
        @(negedge clk);
        hold_cs      = 1'b0;
        sub_reply    = 8'h99;
        data_to_send = 8'hF0;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (650) @(negedge clk);
        doneBefore = doneCount;
        rst = 1'b1;
        @(negedge clk);
        checkOutput("abort_cs", 32'(SPI_CS), 32'd1);
        checkOutput("abort_sclk", 32'(SPI_SCLK), 32'd0);
        checkOutput("abort_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        repeat (1800) @(negedge clk);
        checkOutput("abort_no_done", doneCount, doneBefore);
        checkOutput("scoreboard_empty", expQ.size(), 32'd0);

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule
